grid_renderer: RTL and testbench

- Parametrised step-sequencer grid renderer. Draws a ROWS x COLS grid of CELL_W x CELL_H pixel cells into the VGA pixel writer.
- Each cell has a fill pixel showing its pattern bit. The outline of the current beat column is highlighted.
- Sits between the pattern memory/beat counter and the VGA adapter plot port. It adds a start/busy/done frame handshake and a ready back-pressure input.

---
 rtl/grid_renderer.sv | 256 +++++++++++++++++++++++++
 tb/tb_grid_renderer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_renderer.sv
// rtl/grid_renderer.sv - step-sequencer grid renderer feeding a VGA pixel plot port
// Draws ROWS x COLS cells pixel by pixel with a start/busy/done handshake and ready back-pressure.
module grid_renderer #(
    parameter int ROWS      = 4,
    parameter int COLS      = 16,
    parameter int CELL_W    = 3,
    parameter int CELL_H    = 3,
    parameter int COL_PITCH = 8,
    parameter int ROW_PITCH = 20,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int C_W       = 3,
    parameter logic [C_W-1:0] FILL_ON  = 3'b001,
    parameter logic [C_W-1:0] FILL_OFF = 3'b111,
    parameter logic [C_W-1:0] HILITE   = 3'b110,
    parameter logic [C_W-1:0] BORDER   = 3'b000,
    parameter int BEAT_W    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [X_W-1:0]         x0,
    input  logic [Y_W-1:0]         y0,
    input  logic [ROWS*COLS-1:0]   pattern,
    input  logic [BEAT_W-1:0]      beat,
    input  logic                   ready,
    output logic                   plot,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [C_W-1:0]         colour,
    output logic                   busy,
    output logic                   done
);

    localparam int PX_W  = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int PY_W  = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PAT_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

    localparam logic [PX_W-1:0]  PX_MAX  = PX_W'(CELL_W - 1);
    localparam logic [PY_W-1:0]  PY_MAX  = PY_W'(CELL_H - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [PX_W-1:0]        px_q, px_d;
    logic [PY_W-1:0]        py_q, py_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [X_W-1:0]         sx0_q, sx0_d;
    logic [Y_W-1:0]         sy0_q, sy0_d;
    logic [ROWS*COLS-1:0]   spat_q, spat_d;
    logic [BEAT_W-1:0]      sbeat_q, sbeat_d;
    logic                   plot_q, plot_d;
    logic [X_W-1:0]         x_q, x_d;
    logic [Y_W-1:0]         y_q, y_d;
    logic [C_W-1:0]         colour_q, colour_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [PX_W-1:0]        adv_px;
    logic [PY_W-1:0]        adv_py;
    logic [COL_W-1:0]       adv_col;
    logic [ROW_W-1:0]       adv_row;
    logic                   frame_last;

    logic [X_W-1:0]         src_x0;
    logic [Y_W-1:0]         src_y0;
    logic [ROWS*COLS-1:0]   src_pat;
    logic [BEAT_W-1:0]      src_beat;
    logic [PX_W-1:0]        c_px;
    logic [PY_W-1:0]        c_py;
    logic [COL_W-1:0]       c_col;
    logic [ROW_W-1:0]       c_row;
    logic [PAT_W-1:0]       pat_idx;
    logic                   is_fill;
    logic [X_W-1:0]         pix_x;
    logic [Y_W-1:0]         pix_y;
    logic [C_W-1:0]         pix_c;

    // Counter successor in raster order: px, then py, then col, then row.
    always_comb begin
        adv_px  = px_q;
        adv_py  = py_q;
        adv_col = col_q;
        adv_row = row_q;
        if (px_q == PX_MAX) begin
            adv_px = '0;
            if (py_q == PY_MAX) begin
                adv_py = '0;
                if (col_q == COL_MAX) begin
                    adv_col = '0;
                    adv_row = row_q + ROW_W'(1);
                end else begin
                    adv_col = col_q + COL_W'(1);
                end
            end else begin
                adv_py = py_q + PY_W'(1);
            end
        end else begin
            adv_px = px_q + PX_W'(1);
        end
        frame_last = (px_q == PX_MAX) && (py_q == PY_MAX)
                  && (col_q == COL_MAX) && (row_q == ROW_MAX);
    end

    // Pixel to be presented next: the first pixel from live inputs when a
    // frame starts, otherwise the successor pixel from the snapshot.
    always_comb begin
        if (state_q == S_IDLE) begin
            src_x0   = x0;
            src_y0   = y0;
            src_pat  = pattern;
            src_beat = beat;
            c_px     = '0;
            c_py     = '0;
            c_col    = '0;
            c_row    = '0;
        end else begin
            src_x0   = sx0_q;
            src_y0   = sy0_q;
            src_pat  = spat_q;
            src_beat = sbeat_q;
            c_px     = adv_px;
            c_py     = adv_py;
            c_col    = adv_col;
            c_row    = adv_row;
        end
        pix_x   = X_W'(32'(src_x0) + 32'(c_col) * COL_PITCH + 32'(c_px));
        pix_y   = Y_W'(32'(src_y0) + 32'(c_row) * ROW_PITCH + 32'(c_py));
        pat_idx = PAT_W'(32'(c_row) * COLS + 32'(c_col));
        is_fill = (32'(c_px) == CELL_W / 2) && (32'(c_py) == CELL_H / 2);
        if (is_fill) begin
            pix_c = src_pat[pat_idx] ? FILL_ON : FILL_OFF;
        end else if (32'(c_col) == 32'(src_beat)) begin
            pix_c = HILITE;
        end else begin
            pix_c = BORDER;
        end
    end

    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        col_d    = col_q;
        row_d    = row_q;
        sx0_d    = sx0_q;
        sy0_d    = sy0_q;
        spat_d   = spat_q;
        sbeat_d  = sbeat_q;
        plot_d   = plot_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_DRAW;
                    sx0_d    = x0;
                    sy0_d    = y0;
                    spat_d   = pattern;
                    sbeat_d  = beat;
                    px_d     = '0;
                    py_d     = '0;
                    col_d    = '0;
                    row_d    = '0;
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                    x_d      = pix_x;
                    y_d      = pix_y;
                    colour_d = pix_c;
                end
            end
            S_DRAW: begin
                if (plot_q && ready) begin
                    if (frame_last) begin
                        state_d = S_FIN;
                        plot_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        px_d     = adv_px;
                        py_d     = adv_py;
                        col_d    = adv_col;
                        row_d    = adv_row;
                        x_d      = pix_x;
                        y_d      = pix_y;
                        colour_d = pix_c;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                plot_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            px_q     <= '0;
            py_q     <= '0;
            col_q    <= '0;
            row_q    <= '0;
            sx0_q    <= '0;
            sy0_q    <= '0;
            spat_q   <= '0;
            sbeat_q  <= '0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            py_q     <= py_d;
            col_q    <= col_d;
            row_q    <= row_d;
            sx0_q    <= sx0_d;
            sy0_q    <= sy0_d;
            spat_q   <= spat_d;
            sbeat_q  <= sbeat_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign plot   = plot_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_grid_renderer.sv
// tb/tb_grid_renderer.sv - scoreboard bench for grid_renderer
// Two instances: default geometry (A) and a 12-column variant (B).
module tb_grid_renderer;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;

    logic        start_a, start_b;
    logic [7:0]  x0_a, x0_b;
    logic [6:0]  y0_a, y0_b;
    logic [63:0] pattern_a;
    logic [47:0] pattern_b;
    logic [3:0]  beat_a, beat_b;

    logic        plot_a, plot_b, busy_a, busy_b, done_a, done_b;
    logic [7:0]  x_a, x_b;
    logic [6:0]  y_a, y_b;
    logic [2:0]  colour_a, colour_b;

    logic        sel;
    logic        o_plot, o_busy, o_done;
    logic [7:0]  o_x;
    logic [6:0]  o_y;
    logic [2:0]  o_c;

    int   checks = 0;
    int   errors = 0;
    pix_t exp_q[$];

    int   accepts, hil_cnt, on_cnt, done_c;
    pix_t first_pix, last_pix, on_pix, pix9;

    always #5 clk = ~clk;

    grid_renderer u_a (
        .clk(clk), .reset(reset), .start(start_a), .x0(x0_a), .y0(y0_a),
        .pattern(pattern_a), .beat(beat_a), .ready(ready), .plot(plot_a),
        .x(x_a), .y(y_a), .colour(colour_a), .busy(busy_a), .done(done_a)
    );

    grid_renderer #(.COLS(12)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .x0(x0_b), .y0(y0_b),
        .pattern(pattern_b), .beat(beat_b), .ready(ready), .plot(plot_b),
        .x(x_b), .y(y_b), .colour(colour_b), .busy(busy_b), .done(done_b)
    );

    assign o_plot = sel ? plot_b   : plot_a;
    assign o_busy = sel ? busy_b   : busy_a;
    assign o_done = sel ? done_b   : done_a;
    assign o_x    = sel ? x_b      : x_a;
    assign o_y    = sel ? y_b      : y_a;
    assign o_c    = sel ? colour_b : colour_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pix_t model(input int cols, input logic [7:0] fx0, input logic [6:0] fy0,
                                   input logic [63:0] pat, input int fb, input int idx);
        pix_t m;
        int px, py, col, row;
        px  = idx % 3;
        py  = (idx / 3) % 3;
        col = (idx / 9) % cols;
        row = idx / (9 * cols);
        m.x = 8'(int'(fx0) + col * 8 + px);
        m.y = 7'(int'(fy0) + row * 20 + py);
        if (px == 1 && py == 1) m.c = pat[row * cols + col] ? 3'b001 : 3'b111;
        else                    m.c = (col == fb) ? 3'b110 : 3'b000;
        return m;
    endfunction

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    task automatic start_frame(input int cols, input logic [7:0] fx0, input logic [6:0] fy0,
                               input logic [63:0] pat, input int fb);
        if (sel) begin
            x0_b = fx0; y0_b = fy0; pattern_b = pat[47:0]; beat_b = 4'(fb);
        end else begin
            x0_a = fx0; y0_a = fy0; pattern_a = pat; beat_a = 4'(fb);
        end
        for (int i = 0; i < 4 * cols * 9; i++) exp_q.push_back(model(cols, fx0, fy0, pat, fb, i));
        set_start(1'b1);
        tick();
        set_start(1'b0);
        // Scramble inputs: the frame must keep using the snapshot.
        x0_a = ~fx0; y0_a = ~fy0; pattern_a = ~pat; beat_a = 4'(fb + 1);
        x0_b = ~fx0; y0_b = ~fy0; pattern_b = ~pat[47:0]; beat_b = 4'(fb + 1);
    endtask

    // mode 1 drives ready 1,0,0,1; reset_at > 0 aborts the frame at that cycle.
    task automatic run_frame(input int mode, input int repulse, input int reset_at, input int nexp);
        pix_t got, want, held;
        logic held_valid;
        logic found;
        held_valid = 1'b0;
        found = 1'b0;
        accepts = 0; hil_cnt = 0; on_cnt = 0; done_c = 0;
        for (int c = 1; c < 3000; c++) begin
            ready = (mode == 1) ? ((c % 4 == 1) || (c % 4 == 0)) : 1'b1;
            got = '{x: o_x, y: o_y, c: o_c};
            if (held_valid) begin
                chk("hold_pixel", 32'(got), 32'(held));
                held_valid = 1'b0;
            end
            if (c == reset_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk("rst_plot", 32'(o_plot), 0);
                chk("rst_busy", 32'(o_busy), 0);
                chk("rst_done", 32'(o_done), 0);
                chk("rst_x", 32'(o_x), 0);
                chk("rst_y", 32'(o_y), 0);
                chk("rst_colour", 32'(o_c), 0);
                exp_q.delete();
                for (int k = 0; k < 30; k++) begin
                    tick();
                    chk("post_rst_done", 32'(o_done), 0);
                    chk("post_rst_plot", 32'(o_plot), 0);
                end
                return;
            end
            set_start((repulse != 0) && (c == 100));
            if (o_done) begin
                found = 1'b1;
                done_c = c;
                break;
            end
            chk("plot_draw", 32'(o_plot), 1);
            chk("busy_draw", 32'(o_busy), 1);
            if (ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_pixel", 32'(accepts), 32'(nexp));
                end else begin
                    want = exp_q.pop_front();
                    chk("pixel", 32'(got), 32'(want));
                end
                if (accepts == 0) first_pix = got;
                if (accepts == 9) pix9 = got;
                last_pix = got;
                if (got.c == 3'b110) hil_cnt++;
                if (got.c == 3'b001) begin
                    on_cnt++;
                    on_pix = got;
                end
                accepts++;
            end else begin
                held = got;
                held_valid = 1'b1;
            end
            tick();
        end
        chk("done_seen", 32'(found), 1);
        chk("accept_count", 32'(accepts), 32'(nexp));
        chk("fin_busy", 32'(o_busy), 0);
        chk("fin_plot", 32'(o_plot), 0);
        if (mode == 0) chk("done_cycle", 32'(done_c), 32'(nexp + 1));
        chk("queue_empty", 32'(exp_q.size()), 0);
        if (repulse != 0) set_start(1'b1);
        tick();
        set_start(1'b0);
        for (int k = 0; k < 20; k++) begin
            chk("after_done", 32'(o_done), 0);
            chk("after_plot", 32'(o_plot), 0);
            tick();
        end
    endtask

    initial begin
        sel = 1'b0; reset = 1'b1; ready = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        x0_a = '0; y0_a = '0; pattern_a = '0; beat_a = '0;
        x0_b = '0; y0_b = '0; pattern_b = '0; beat_b = '0;
        tick(); tick();
        start_a = 1'b1;
        tick();
        chk("reset_plot", 32'(plot_a), 0);
        chk("reset_x", 32'(x_a), 0);
        chk("reset_y", 32'(y_a), 0);
        chk("reset_colour", 32'(colour_a), 0);
        chk("reset_busy", 32'(busy_a), 0);
        chk("reset_done", 32'(done_a), 0);
        start_a = 1'b0;
        reset = 1'b0;
        tick();

        // Blank pattern, beat 3
        start_frame(16, 8'd8, 7'd50, 64'd0, 3);
        run_frame(0, 0, 0, 576);
        chk("first_pixel", 32'(first_pix), 32'(pix_t'{x: 8'd8, y: 7'd50, c: 3'b000}));
        chk("last_pixel", 32'(last_pix), 32'(pix_t'{x: 8'd130, y: 7'd112, c: 3'b000}));
        chk("hilite_count", 32'(hil_cnt), 32);

        // One set cell at row 1 col 2
        start_frame(16, 8'd8, 7'd50, 64'd1 << 18, 3);
        run_frame(0, 0, 0, 576);
        chk("on_count", 32'(on_cnt), 1);
        chk("on_pixel", 32'(on_pix), 32'(pix_t'{x: 8'd25, y: 7'd71, c: 3'b001}));

        // Back-pressure
        start_frame(16, 8'd8, 7'd50, 64'hA5C3_0F96_1234_8001, 5);
        run_frame(1, 0, 0, 576);

        // start re-pulsed mid-frame and in FIN
        start_frame(16, 8'd8, 7'd50, 64'h0000_FFFF_0000_FFFF, 0);
        run_frame(0, 1, 0, 576);

        // Reset mid-frame, then a clean frame
        start_frame(16, 8'd8, 7'd50, 64'd0, 3);
        run_frame(0, 0, 200, 576);
        start_frame(16, 8'd8, 7'd50, 64'd0, 3);
        run_frame(0, 0, 0, 576);
        chk("post_rst_first", 32'(first_pix), 32'(pix_t'{x: 8'd8, y: 7'd50, c: 3'b000}));

        // 12 columns, wrapping x, out-of-range beat
        sel = 1'b1;
        start_frame(12, 8'd250, 7'd10, 64'h0000_9F3C_5A61_0E27, 13);
        run_frame(0, 0, 0, 432);
        chk("no_hilite", 32'(hil_cnt), 0);
        chk("col1_wrap_x", 32'(pix9.x), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
